logic_unit_acc: RTL and testbench
=================================

// Module: logic_unit_acc
// PURPOSE
//  Parametrised, registered bitwise logic unit. Generalises fixed-width single-op gate arrays to WIDTH bits and eight ops.
//  Adds a multi-beat accumulate (reduction) mode and valid/ready flow control on both sides.
//  Sits between operand sources and ALU result muxes; a one-entry output register decouples producer and consumer.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
//  ACC_EN  1   1 = accumulate mode available; 0 = inAcc ignored, unit is a pure per-beat op
// PORTS
//  clk       in   1      clock, all state on rising edge
//  rst_n     in   1      asynchronous active-low reset
//  inValid   in   1      input beat valid
//  inReady   out  1      unit can accept a beat this cycle
//  inA       in   WIDTH  operand X (normal) / element (accumulate)
//  inB       in   WIDTH  operand Y (normal mode only; ignored in accumulate)
//  inOp      in   3      000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT X, 111 PASS X
//  inAcc     in   1      beat belongs to an accumulation
//  inLast    in   1      final beat of an accumulation (ignored when inAcc=0)
//  outValid  out  1      result valid
//  outReady  in   1      consumer accepts result
//  outY      out  WIDTH  registered result
//  outZero   out  1      outY == 0
//  outOnes   out  1      outY == all ones
// BEHAVIOUR
//  - f(op,X,Y) is the bitwise function selected by inOp; it is evaluated per bit, with no carries and no width growth.
//  - A beat is accepted when inValid && inReady. Define inReady = !outValid || outReady, which allows full throughput.
//  - Producing beat: outY and outValid are loaded on the accept edge, giving 1-cycle latency.
//  - outValid holds, and outY is stable, until the cycle with outValid && outReady.
//  - Non-producing beat (accumulate, not last): only the accumulator updates; outValid and outY are unchanged.
//  - Reset values: outValid=0, outY=0, outZero=1, outOnes=0, acc=0, state=IDLE.
//  - outZero and outOnes are decoded from the outY register and so track it with zero added latency.
//  - Normal beat (inAcc=0 or ACC_EN=0): producing, outY = f(inOp, inA, inB). The state is forced to IDLE.
//  - FSM states: IDLE (no accumulation open) and ACCUM (accumulator holds a partial result).
//  - IDLE, acc beat, inLast=0: acc <= inA and the state goes to ACCUM. inOp is not applied to the first element.
//  - IDLE, acc beat, inLast=1: producing, outY = inA, and the state stays IDLE.
//  - ACCUM, acc beat, inLast=0: acc <= f(inOp, acc, inA) and the state stays ACCUM.
//  - ACCUM, acc beat, inLast=1: producing, outY = f(inOp, acc, inA), and the state goes to IDLE.
//  - ACCUM, normal beat: the open accumulation is silently discarded. The beat is processed as normal and the state goes to IDLE.
//  - inOp is sampled per beat, so ops may change between beats of one accumulation.
//  - NOT X and PASS X in accumulate mode act on acc only, giving acc <= ~acc or acc <= acc; inA is ignored.
//  - Accumulate beats obey the same inReady as producing beats, so a stalled output stalls the accumulation too.
//  - inValid=0 leaves all state unchanged. Inputs are don't-care while not accepted.
//  - Reset mid-accumulation or with outValid=1 returns immediately to the reset values; the partial result and pending output are lost.
// TESTING (WIDTH=8, ACC_EN=1)
//  - All eight ops, A=0xA5, B=0x3C, outReady=1. Expected outY one cycle later:
//      0x24 (AND), 0xBD (OR), 0x99 (XOR), 0xDB (NAND), 0x42 (NOR), 0x66 (XNOR), 0x5A (NOT X), 0xA5 (PASS X).
//    outZero and outOnes must be 0 for every op.
//  - OR accumulation of beats 0x01, 0x10, 0x80(last) gives a single output 0x91.
//    outValid must stay 0 until the third beat has been accepted.
//  - Backpressure: drive back-to-back AND beats with outReady=0.
//    The first result holds outY stable and inReady=0. When outReady goes to 1, both results emerge in order with no loss.
//  - Single-beat accumulation 0xFF with inLast=1 -> outY=0xFF and outOnes=1.
//    Then XOR-accumulate 0x0F, 0x0F(last) -> outY=0x00 and outZero=1.
//  - Abort: accumulate 0x01 (not last), then a normal OR beat with A=0x02, B=0x04.
//    outY=0x06. The next accumulation must start fresh: 0x08(last) -> outY=0x08.
//  - Assert rst_n=0 asynchronously mid-accumulation with outValid=1.
//    Outputs clear immediately, without waiting for a clock edge. After release, single-beat 0x33 -> outY=0x33.

Source files
------------

// File: rtl/logic_unit_acc.sv
// Registered WIDTH-bit bitwise logic unit with eight ops, an optional multi-beat
// accumulate (reduction) mode and valid/ready flow control on both sides.
module logic_unit_acc #(
    parameter int WIDTH  = 8,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       inOp,
    input  logic             inAcc,
    input  logic             inLast,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outY,
    output logic             outZero,
    output logic             outOnes,
    output logic             stateDbg
);

    // Handshake: a beat transfers on a rising edge where inValid && inReady; a
    // result transfers where outValid && outReady. inReady = !outValid || outReady,
    // so accumulate beats stall behind an unconsumed result exactly like producing beats.

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             is_acc;
    logic             produce;
    logic             acc_load;
    logic [WIDTH-1:0] res_val;
    logic [WIDTH-1:0] acc_val;

    function automatic logic [WIDTH-1:0] bitop(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady;
    assign is_acc  = ACC_EN && inAcc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A normal beat always closes (or discards) any open accumulation.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (!is_acc || inLast) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = ACCUM;
            end
        end
    end

    always_comb begin
        produce  = 1'b0;
        acc_load = 1'b0;
        res_val  = '0;
        acc_val  = acc;
        stateDbg = (state == ACCUM);
        if (accept) begin
            if (!is_acc) begin
                produce = 1'b1;
                res_val = bitop(inOp, inA, inB);
            end else if (state == IDLE) begin
                // The first element is taken as-is; inOp only combines later elements.
                produce  = inLast;
                acc_load = !inLast;
                res_val  = inA;
                acc_val  = inA;
            end else begin
                produce  = inLast;
                acc_load = !inLast;
                res_val  = bitop(inOp, acc, inA);
                acc_val  = bitop(inOp, acc, inA);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= acc_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outY     <= '0;
        end else if (produce) begin
            outValid <= 1'b1;
            outY     <= res_val;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    assign outZero = (outY == '0);
    assign outOnes = (outY == '1);

endmodule

// File: tb/tb_logic_unit_acc.sv
// Self-checking bench for logic_unit_acc (WIDTH=8, ACC_EN=1): op table, directed
// accumulation/backpressure/abort/reset sequences and a randomized run against a model.
module tb_logic_unit_acc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic [2:0]   inOp = '0;
    logic         inAcc = 1'b0;
    logic         inLast = 1'b0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [W-1:0] outY;
    logic         outZero;
    logic         outOnes;
    logic         stateDbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic         rand_rdy  = 1'b0;
    logic         fixed_rdy = 1'b1;
    logic [W-1:0] exp_q[$];

    logic         mdl_open = 1'b0;
    logic [W-1:0] mdl_acc  = '0;

    logic         hold_valid = 1'b0;
    logic [W-1:0] hold_y     = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] y;
    } vec_t;
    vec_t vecs[8];

    logic_unit_acc #(.WIDTH(W), .ACC_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .inA(inA), .inB(inB), .inOp(inOp), .inAcc(inAcc), .inLast(inLast),
        .outValid(outValid), .outReady(outReady), .outY(outY),
        .outZero(outZero), .outOnes(outOnes), .stateDbg(stateDbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // single owner of outReady, updated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) outReady = 1'($urandom_range(0, 1));
            else          outReady = fixed_rdy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: each op as plain bitwise arithmetic on the whole word
    function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] tbl[8];
        tbl[0] = x & y;
        tbl[1] = x | y;
        tbl[2] = x ^ y;
        tbl[3] = ~(x & y);
        tbl[4] = ~(x | y);
        tbl[5] = ~(x ^ y);
        tbl[6] = ~x;
        tbl[7] = x;
        return tbl[op];
    endfunction

    // model step at an accepted beat; pushes the expected result of producing beats
    task automatic model_step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                              input logic acc, input logic last,
                              input logic use_exp, input logic [W-1:0] exp_v);
        logic         prod;
        logic [W-1:0] v;
        prod = 1'b0;
        v    = '0;
        if (!acc) begin
            prod     = 1'b1;
            v        = ref_f(op, a, b);
            mdl_open = 1'b0;
        end else if (!mdl_open) begin
            if (last) begin
                prod = 1'b1;
                v    = a;
            end else begin
                mdl_open = 1'b1;
                mdl_acc  = a;
            end
        end else begin
            v = ref_f(op, mdl_acc, a);
            if (last) begin
                prod     = 1'b1;
                mdl_open = 1'b0;
            end else begin
                mdl_acc = v;
            end
        end
        if (prod) exp_q.push_back(use_exp ? exp_v : v);
    endtask

    // driver: present beat from a falling edge, hold until accepted (bounded)
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                             input logic acc, input logic last,
                             input logic use_exp, input logic [W-1:0] exp_v);
        int waitc;
        waitc = 0;
        @(negedge clk);
        inA = a; inB = b; inOp = op; inAcc = acc; inLast = last; inValid = 1'b1;
        while (!inReady && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!inReady) begin
            chk("accept_timeout", 32'(inReady), 32'd1);
            inValid = 1'b0;
            return;
        end
        model_step(a, b, op, acc, last, use_exp, exp_v);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while ((exp_q.size() != 0 || outValid) && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_outValid"}, 32'(outValid), 32'd0);
        chk({tag, "_outY"},     32'(outY),     32'd0);
        chk({tag, "_outZero"},  32'(outZero),  32'd1);
        chk({tag, "_outOnes"},  32'(outOnes),  32'd0);
        chk({tag, "_inReady"},  32'(inReady),  32'd1);
        chk({tag, "_state"},    32'(stateDbg), 32'd0);
    endtask

    // asynchronous reset asserted mid-cycle, checked before any clock edge
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        exp_q.delete();
        mdl_open = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // scoreboard: result transfers and stability while stalled
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    chk("hold_valid", 32'(outValid), 32'd1);
                    chk("hold_y", 32'(outY), 32'(hold_y));
                end
                if (outValid && outReady) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'(outY), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("outY", 32'(outY), 32'(e));
                        chk("outZero", 32'(outZero), 32'(e == '0));
                        chk("outOnes", 32'(outOnes), 32'(e == '1));
                    end
                end
                hold_valid = outValid && !outReady;
                hold_y     = outY;
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 3'd0, 8'h24};
        vecs[1] = '{8'hA5, 8'h3C, 3'd1, 8'hBD};
        vecs[2] = '{8'hA5, 8'h3C, 3'd2, 8'h99};
        vecs[3] = '{8'hA5, 8'h3C, 3'd3, 8'hDB};
        vecs[4] = '{8'hA5, 8'h3C, 3'd4, 8'h42};
        vecs[5] = '{8'hA5, 8'h3C, 3'd5, 8'h66};
        vecs[6] = '{8'hA5, 8'h3C, 3'd6, 8'h5A};
        vecs[7] = '{8'hA5, 8'h3C, 3'd7, 8'hA5};

        #3;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // all eight ops, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0, 1'b1, vecs[i].y);
            chk("latency_valid", 32'(outValid), 32'd1);
            chk("latency_y", 32'(outY), 32'(vecs[i].y));
        end
        drain();

        // OR accumulation: no output until the last beat
        send_beat(8'h01, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("acc1_valid", 32'(outValid), 32'd0);
        chk("acc1_state", 32'(stateDbg), 32'd1);
        send_beat(8'h10, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("acc2_valid", 32'(outValid), 32'd0);
        send_beat(8'h80, 8'h00, 3'd1, 1'b1, 1'b1, 1'b1, 8'h91);
        chk("acc3_valid", 32'(outValid), 32'd1);
        chk("acc3_state", 32'(stateDbg), 32'd0);
        drain();

        // backpressure: second AND beat waits behind the held first result
        fixed_rdy = 1'b0;
        @(posedge clk);
        #2;
        send_beat(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b1, 8'h30);
        fork
            send_beat(8'h0F, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1, 8'h0F);
            begin
                repeat (3) @(negedge clk);
                chk("bp_inReady", 32'(inReady), 32'd0);
                chk("bp_outY", 32'(outY), 32'h30);
                chk("bp_outValid", 32'(outValid), 32'd1);
                fixed_rdy = 1'b1;
            end
        join
        drain();

        // single-beat all-ones, then XOR self-cancel to zero
        send_beat(8'hFF, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hFF);
        send_beat(8'h0F, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00);
        send_beat(8'h0F, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1, 8'h00);
        drain();

        // abort an open accumulation with a normal beat, then start fresh
        send_beat(8'h01, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        send_beat(8'h02, 8'h04, 3'd1, 1'b0, 1'b0, 1'b1, 8'h06);
        chk("abort_state", 32'(stateDbg), 32'd0);
        send_beat(8'h08, 8'h00, 3'd1, 1'b1, 1'b1, 1'b1, 8'h08);
        drain();

        // reset with a pending, unconsumed output
        fixed_rdy = 1'b0;
        @(posedge clk);
        #2;
        send_beat(8'hA5, 8'h3C, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("pend_valid", 32'(outValid), 32'd1);
        mid_reset("rst_pend");
        fixed_rdy = 1'b1;
        @(posedge clk);
        #2;
        // reset mid-accumulation; a fresh XOR single beat must not see the old acc
        send_beat(8'h01, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_rst_state", 32'(stateDbg), 32'd1);
        mid_reset("rst_acc");
        send_beat(8'h33, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1, 8'h33);
        drain();

        // randomized traffic against the model
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic acc_b;
            logic last_b;
            acc_b  = ($urandom_range(0, 99) < 60);
            last_b = ($urandom_range(0, 99) < 35);
            send_beat(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                      acc_b, last_b, 1'b0, 8'h00);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_rdy  = 1'b0;
        fixed_rdy = 1'b1;
        send_beat(8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
